// File: rtl/aes_enc_iter_if.sv
// rtl/aes_enc_iter_if.sv - plaintext/key in and ciphertext out handshake bundle for aes_enc_iter
interface aes_enc_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   modport master (
      output in_valid, in_key, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_key, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] w_inv;

   assign w_inv  = gf_inv(i_byte);
   assign o_byte = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;
endmodule

module aes_enc_iter (
   input  logic            clk,
   input  logic            rst_n,
   aes_enc_iter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       r_state;
   logic [3:0]   r_rnd;
   logic [127:0] r_st;
   logic [127:0] r_rk;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         r_busy;

   logic [127:0] w_sb;
   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [31:0]  w_k0;
   logic [31:0]  w_k1;
   logic [31:0]  w_k2;
   logic [31:0]  w_k3;
   logic [127:0] w_next_rk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i of the column-major state sits at [127-8*i -: 8]; row r of column c is byte 4*c+r
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)&3)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   for (genvar gi = 0; gi < 16; gi++) begin : g_st_sbox
      aes_sbox u_sbox (.i_byte(r_st[127-8*gi -: 8]), .o_byte(w_sb[127-8*gi -: 8]));
   end

   assign w_rot = {r_rk[23:0], r_rk[31:24]};

   for (genvar gk = 0; gk < 4; gk++) begin : g_key_sbox
      aes_sbox u_sbox (.i_byte(w_rot[31-8*gk -: 8]), .o_byte(w_sub[31-8*gk -: 8]));
   end

   assign w_k0      = r_rk[127:96] ^ w_sub ^ {rcon(r_rnd), 24'h000000};
   assign w_k1      = r_rk[95:64]  ^ w_k0;
   assign w_k2      = r_rk[63:32]  ^ w_k1;
   assign w_k3      = r_rk[31:0]   ^ w_k2;
   assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};
   assign w_sr      = shift_rows(w_sb);
   assign w_mc      = mix_columns(w_sr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rnd       <= 4'd0;
         r_st        <= '0;
         r_rk        <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_st       <= bus.in_data ^ bus.in_key;
                  r_rk       <= bus.in_key;
                  r_rnd      <= 4'd1;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ROUND;
               end
            end
            ROUND: begin
               r_rk  <= w_next_rk;
               r_rnd <= r_rnd + 4'd1;
               if (r_rnd == 4'd10) begin
                  r_st        <= w_sr ^ w_next_rk;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_st <= w_mc ^ w_next_rk;
               end
            end
            DONE: begin
               // in_ready only returns the cycle after the handshake
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_st;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - directed FIPS-197 vectors, handshake timing, backpressure and reset checks
module tb_aes_enc_iter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes_enc_iter_if bus ();

   aes_enc_iter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   // Accept one block, scramble the inputs right after, check latency and ciphertext, then handshake
   task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] ct, input string tag);
      int n;
      check($sformatf("%s_ready", tag), 128'(bus.in_ready), 128'd1);
      bus.in_valid  = 1'b1;
      bus.in_key    = key;
      bus.in_data   = pt;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_key   = ~key;
      bus.in_data  = ~pt;
      check($sformatf("%s_busy", tag), 128'({bus.busy, bus.in_ready}), 128'b10);
      wait_out(n);
      check($sformatf("%s_latency", tag), 128'(n), 128'd10);
      check($sformatf("%s_ct", tag), bus.out_data, ct);
      step();
      check($sformatf("%s_release", tag), 128'({bus.out_valid, bus.in_ready}), 128'b01);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got 0 exp 1");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      int ndone;
      int sent_c;
      int t0;
      int t1;
      int cyc;
      logic [127:0] d0;
      logic [127:0] d1;

      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_key    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctl", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'b100);
      check("reset_data", bus.out_data, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_block(KEY_B, PT_B, CT_B, "fips_b");
      run_block(KEY_C, PT_C, CT_C, "fips_c1");

      // Backpressure: C1 held in DONE while a new block is offered continuously
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_key    = KEY_C;
      bus.in_data   = PT_C;
      step();
      bus.in_key  = KEY_B;
      bus.in_data = PT_B;
      wait_out(n);
      check("bp_latency", 128'(n), 128'd10);
      for (int i = 0; i < 20; i++) begin
         step();
         check("bp_hold_data", bus.out_data, CT_C);
         check("bp_hold_ctl", 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'b100);
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_release", 128'({bus.out_valid, bus.in_ready}), 128'b01);
      step();
      bus.in_valid = 1'b0;
      check("bp_accept", 128'({bus.busy, bus.in_ready}), 128'b10);
      wait_out(n);
      check("bp_latency2", 128'(n), 128'd10);
      check("bp_ct", bus.out_data, CT_B);
      step();
      check("bp_idle", 128'(bus.in_ready), 128'd1);

      // Back-to-back with out_ready tied high and in_valid held
      bus.in_valid = 1'b1;
      bus.in_key   = KEY_B;
      bus.in_data  = PT_B;
      ndone  = 0;
      sent_c = 0;
      cyc    = 0;
      t0 = 0; t1 = 0; d0 = '0; d1 = '0;
      while (ndone < 2 && cyc < 60) begin
         step();
         cyc++;
         if (sent_c == 0 && bus.in_ready == 1'b0) begin
            bus.in_key  = KEY_C;
            bus.in_data = PT_C;
            sent_c      = 1;
         end
         if (bus.out_valid) begin
            if (ndone == 0) begin t0 = cyc; d0 = bus.out_data; end
            else begin t1 = cyc; d1 = bus.out_data; bus.in_valid = 1'b0; end
            ndone++;
         end
      end
      check("b2b_count", 128'(ndone), 128'd2);
      check("b2b_ct0", d0, CT_B);
      check("b2b_ct1", d1, CT_C);
      check("b2b_spacing", 128'(t1 - t0), 128'd12);
      step();
      check("b2b_idle", 128'({bus.out_valid, bus.in_ready}), 128'b01);

      // Asynchronous reset during round 5
      bus.in_valid = 1'b1;
      bus.in_key   = KEY_B;
      bus.in_data  = PT_B;
      step();
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("rst_pre_busy", 128'(bus.busy), 128'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async", 128'({bus.busy, bus.out_valid, bus.in_ready}), 128'b001);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1;
      end
      check("rst_no_output", 128'(seen), 128'd0);
      run_block(KEY_C, PT_C, CT_C, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Iterative AES-128 encryption core. It is the forward (cipher) counterpart of the decrypt-path inverse-round logic.
- Accepts one 128-bit plaintext block plus a 128-bit cipher key over a valid/ready handshake. It performs one full round per clock, generating round keys on the fly.
- Presents the ciphertext on a valid/ready output.
- Sits in the AES encrypt path beside the decrypt datapath. Uses the same column-major state byte order.

Parameters:
- None. The block is AES-128 only, with the round count fixed at 10.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext/key present.
- in_ready  output  1  core can accept a block.
- in_key  input  128  cipher key; in_key[127:120] is key byte 0.
- in_data  input  128  plaintext; in_data[127:120] = s0 … in_data[7:0] = s15, column-major (s0..s3 = column 0).
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts ciphertext.
- out_data  output  128  ciphertext, same byte order as in_data.
- busy  output  1  high while rounds are in progress.

Behaviour:
- States: IDLE, ROUND, DONE. A 4-bit round counter rnd, a 128-bit state register st, and a 128-bit round-key register rk.
- Reset (async, rst_n=0):
  - state=IDLE, rnd=0, st=0, rk=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
  - Reset asserted mid-operation aborts the block immediately; no output is produced.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&&in_ready: st<=in_data^in_key (initial AddRoundKey), rk<=in_key, rnd<=1, state<=ROUND.
  - in_key and in_data are sampled only on this edge and need not be held afterwards.
- ROUND (in_ready=0, busy=1): each edge performs one round.
  - next_rk = KeyExpand(rk, rcon[rnd]).
    - rcon = 01,02,04,08,10,20,40,80,1b,36 for rnd=1..10.
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - t = ShiftRows(SubBytes(st)).
    - Forward ShiftRows = {s0,s5,s10,s15, s4,s9,s14,s3, s8,s13,s2,s7, s12,s1,s6,s11} (row r rotated left by r).
  - rnd 1..9: st<=MixColumns(t)^next_rk. MixColumns is the standard GF(2^8) matrix [02 03 01 01] per column, xtime reduction by 0x1b.
  - rnd 10: st<=t^next_rk (no MixColumns), state<=DONE.
  - rk<=next_rk; rnd<=rnd+1.
  - S-boxes: 16 state plus 4 key-schedule lookups per cycle, purely combinational, using the team's forward sbox module.
- DONE:
  - out_valid=1, out_data=st, busy=0, in_ready=0.
  - out_data is held stable until the handshake.
  - On the edge with out_valid&&out_ready: state<=IDLE, out_valid<=0. in_ready rises in the following cycle; there is no same-cycle accept.
- Latency: accept edge at cycle N → out_valid high after edge N+10.
  - Throughput: one block per at least 12 cycles.
  - out_ready held high → out_valid lasts exactly one cycle.
- in_valid during ROUND or DONE is ignored and does not disturb the operation.
- out_ready while not in DONE is ignored.
- out_data outside DONE is don't-care for checking, but is driven from st, which is never X.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32, and out_valid rises exactly 10 cycles after the accept edge.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid rises, with in_valid=1 and new data the whole time.
  - Required: out_data and out_valid are stable, in_ready=0, and no second block is accepted. After out_ready=1 for one cycle, in_ready=1 the next cycle and the new block encrypts correctly.
- Back-to-back:
  - Stimulus: two App. B/C.1 blocks with out_ready tied to 1 and in_valid=1 continuously.
  - Required: both ciphertexts are correct, with out_valid pulses 12 cycles apart.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at round 5, then release.
  - Required: immediately busy=0, out_valid=0, in_ready=1. No output is produced. The next block yields the correct ciphertext.
- Key/data change after accept:
  - Stimulus: change in_key and in_data one cycle after the accept edge.
  - Required: the ciphertext still matches the originally sampled values.
